// File: rtl/truth_table_sweeper.sv
// Exhaustive sweeper: walks all 2**N_IN input vectors of a combinational block, captures f after
// a settle time, and checks the captured truth table against a golden signature latched at start.
module truth_table_sweeper #(
    parameter int N_IN       = 5,
    parameter int SETTLE_CYC = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [2**N_IN-1:0]   expected,
    input  logic                 f_in,
    output logic [N_IN-1:0]      vec_out,
    output logic                 busy,
    output logic                 done,
    output logic [2**N_IN-1:0]   table_out,
    output logic                 pass,
    output logic [N_IN:0]        mismatch_cnt,
    output logic [N_IN-1:0]      first_fail
);

    localparam int              TBL_W     = 2**N_IN;
    localparam logic [7:0]      SETTLE_LD = 8'(SETTLE_CYC);
    localparam logic [N_IN-1:0] LAST_IDX  = {N_IN{1'b1}};
    localparam logic [N_IN-1:0] IDX_ONE   = {{(N_IN-1){1'b0}}, 1'b1};
    localparam logic [N_IN:0]   CNT_ONE   = {{N_IN{1'b0}}, 1'b1};

    typedef enum logic [1:0] {IDLE, SETTLE, SAMPLE, DONE} state_t;

    state_t             state_q, state_d;
    logic [N_IN-1:0]    idx_q, idx_d;
    logic [7:0]         cnt_q, cnt_d;
    logic [TBL_W-1:0]   exp_q, exp_d;
    logic [TBL_W-1:0]   tbl_q, tbl_d;
    logic [N_IN:0]      mis_q, mis_d;
    logic [N_IN-1:0]    ff_q, ff_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               pass_q, pass_d;

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        exp_d   = exp_q;
        tbl_d   = tbl_q;
        mis_d   = mis_q;
        ff_d    = ff_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        pass_d  = pass_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    exp_d   = expected;
                    idx_d   = '0;
                    tbl_d   = '0;
                    mis_d   = '0;
                    ff_d    = '0;
                    pass_d  = 1'b0;
                    cnt_d   = SETTLE_LD;
                    busy_d  = 1'b1;
                    state_d = SETTLE;
                end
            end
            SETTLE: begin
                if (cnt_q <= 8'd1) begin
                    cnt_d   = '0;
                    state_d = SAMPLE;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            SAMPLE: begin
                tbl_d[idx_q] = f_in;
                if (f_in != exp_q[idx_q]) begin
                    mis_d = mis_q + CNT_ONE;
                    if (mis_q == '0) ff_d = idx_q;
                end
                // Terminal index ends the sweep; pass must see the final sample's count.
                if (idx_q == LAST_IDX) begin
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    pass_d  = (mis_d == '0);
                    state_d = DONE;
                end else begin
                    idx_d   = idx_q + IDX_ONE;
                    cnt_d   = SETTLE_LD;
                    state_d = SETTLE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
            cnt_q   <= '0;
            tbl_q   <= '0;
            mis_q   <= '0;
            ff_q    <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            tbl_q   <= tbl_d;
            mis_q   <= mis_d;
            ff_q    <= ff_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            pass_q  <= pass_d;
        end
    end

    // Golden signature only matters once a sweep has been accepted.
    always_ff @(posedge clk) begin
        exp_q <= exp_d;
    end

    assign vec_out      = idx_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign table_out    = tbl_q;
    assign pass         = pass_q;
    assign mismatch_cnt = mis_q;
    assign first_fail   = ff_q;

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Bench for truth_table_sweeper: two instances (settle 1 and 4) swept together against a
// table-level reference model, with random signatures and functions plus the edge cases.
module tb_truth_table_sweeper;

    logic        clk = 1'b0;
    logic        rst, start;
    logic [31:0] expected;
    logic        f1, f4;
    logic [4:0]  vec1, vec4, ff1, ff4;
    logic        busy1, busy4, done1, done4, pass1, pass4;
    logic [31:0] tbl1, tbl4;
    logic [5:0]  mis1, mis4;

    int          mode = 0;
    logic [31:0] func_tt = '0;
    logic [2:0]  dly1 = '0, dly4 = '0;
    logic        last_a = 1'b0;
    int          n_vec = 0, n_mis = 0;

    always #5 clk = ~clk;

    truth_table_sweeper #(.N_IN(5), .SETTLE_CYC(1)) u_dut1 (
        .clk(clk), .rst(rst), .start(start), .expected(expected), .f_in(f1),
        .vec_out(vec1), .busy(busy1), .done(done1), .table_out(tbl1), .pass(pass1),
        .mismatch_cnt(mis1), .first_fail(ff1));

    truth_table_sweeper #(.N_IN(5), .SETTLE_CYC(4)) u_dut4 (
        .clk(clk), .rst(rst), .start(start), .expected(expected), .f_in(f4),
        .vec_out(vec4), .busy(busy4), .done(done4), .table_out(tbl4), .pass(pass4),
        .mismatch_cnt(mis4), .first_fail(ff4));

    // Mode 0: ideal block given by a truth table. Mode 1: input a seen through a 3-cycle delay.
    always @(posedge clk) begin
        dly1 <= {dly1[1:0], vec1[4]};
        dly4 <= {dly4[1:0], vec4[4]};
    end
    assign f1 = (mode == 0) ? func_tt[vec1] : dly1[2];
    assign f4 = (mode == 0) ? func_tt[vec4] : dly4[2];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
        n_vec++;
        if (got !== want) begin
            n_mis++;
            $display("FAIL %s: got %0h, want %0h", tag, got, want);
        end
    endtask

    // Table-level model: what f looks like at each vector's sample point, then the comparison.
    task automatic model(input int s, input logic [31:0] ex, input int md, input logic [31:0] tt,
                         input logic la, output logic [31:0] tb, output logic [5:0] mc,
                         output logic [4:0] ff);
        int lag, src;
        logic b;
        tb = '0; mc = '0; ff = '0;
        lag = (3 + s) / (s + 1) - 1;
        for (int k = 0; k < 32; k++) begin
            if (md == 0) b = tt[k];
            else begin
                src = k - lag;
                b = (src < 0) ? la : (src >= 16);
            end
            tb[k] = b;
            if (b != ex[k]) begin
                if (mc == 0) ff = 5'(k);
                mc++;
            end
        end
    endtask

    // Called at a negedge; returns at the negedge of the first IDLE cycle after both sweeps.
    task automatic run_sweep(input string nm, input logic [31:0] ex, input int md,
                             input logic [31:0] tt);
        logic [31:0] t1, t4;
        logic [5:0]  m1, m4;
        logic [4:0]  x1, x4;
        int d1, d4;
        model(1, ex, md, tt, last_a, t1, m1, x1);
        model(4, ex, md, tt, last_a, t4, m4, x4);
        mode = md; func_tt = tt; expected = ex; start = 1'b1;
        d1 = 0; d4 = 0;
        for (int c = 1; c <= 400; c++) begin
            @(negedge clk);
            start = 1'b0;
            if (c == 1) begin
                chk({nm, " busy_on"}, {busy1, busy4}, 2'b11);
                chk({nm, " vec0"}, {vec1, vec4}, '0);
                chk({nm, " cleared"}, {tbl1, mis1, ff1, pass1}, '0);
            end
            if (c == 5) expected = $urandom;
            if (c == 10) start = 1'b1;
            if (done1 && d1 != 0) chk({nm, " done1_extra"}, 1, 0);
            if (done1 && d1 == 0) begin
                d1 = c;
                chk({nm, " tbl1"}, tbl1, t1);
                chk({nm, " mis1"}, mis1, m1);
                chk({nm, " ff1"}, ff1, x1);
                chk({nm, " pass1"}, pass1, (m1 == 0));
                chk({nm, " busy1_off"}, busy1, 0);
                start = 1'b1;
            end
            if (d1 != 0 && c == d1 + 3) chk({nm, " no_restart1"}, busy1, 0);
            if (done4 && d4 == 0) begin
                d4 = c;
                chk({nm, " tbl4"}, tbl4, t4);
                chk({nm, " mis4"}, mis4, m4);
                chk({nm, " ff4"}, ff4, x4);
                chk({nm, " pass4"}, pass4, (m4 == 0));
                chk({nm, " busy4_off"}, busy4, 0);
            end
            if (d1 != 0 && d4 != 0 && c > d4) break;
        end
        chk({nm, " lat1"}, d1, 65);
        chk({nm, " lat4"}, d4, 161);
        chk({nm, " idle"}, {busy1, busy4, done1, done4}, '0);
        chk({nm, " hold"}, {tbl1, tbl4, mis1, mis4}, {t1, t4, m1, m4});
        last_a = 1'b1;
    endtask

    initial begin
        logic [31:0] ex, tt;
        int md;
        bit found;
        rst = 1'b1; start = 1'b0; expected = '0;
        repeat (3) @(negedge clk);
        chk("reset_state", {vec1, busy1, done1, tbl1, pass1, mis1, ff1}, '0);
        rst = 1'b0;
        @(negedge clk);

        run_sweep("identity", 32'hAAAA_AAAA, 0, 32'hAAAA_AAAA);
        run_sweep("stuck0", 32'hFFFF_FFFF, 0, 32'h0);
        run_sweep("single", 32'h0, 0, 32'h0040_0000);
        run_sweep("settle", 32'hFFFF_0000, 1, 32'h0);

        // Reset in the middle of a sweep, with start held high to show reset has priority.
        mode = 0; func_tt = 32'h1234_5678; expected = 32'h1234_5678; start = 1'b1;
        found = 0;
        for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            start = 1'b0;
            if (vec1 == 5'd10) begin found = 1; break; end
        end
        chk("rst_reach_vec10", found, 1);
        rst = 1'b1; start = 1'b1;
        @(negedge clk);
        chk("rst_mid1", {vec1, busy1, done1, tbl1, pass1, mis1, ff1}, '0);
        chk("rst_mid4", {vec4, busy4, done4, tbl4, pass4, mis4, ff4}, '0);
        rst = 1'b0; start = 1'b0; last_a = 1'b0;
        repeat (4) @(negedge clk);
        chk("rst_stays_idle", {busy1, busy4}, '0);
        run_sweep("after_rst", 32'h1234_5678, 0, 32'h1234_5678);

        for (int i = 0; i < 8; i++) begin
            md = $urandom_range(0, 1);
            tt = $urandom;
            ex = ($urandom_range(0, 2) == 0) ? tt : 32'($urandom);
            if (md == 1 && $urandom_range(0, 1) == 1) ex = 32'hFFFF_0000;
            run_sweep($sformatf("rand%0d", i), ex, md, tt);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule
